l1_dcache_wb: RTL and testbench

Parametrised N-way set-associative L1 data cache between the CPU load/store stage and the next memory level.
- Write-back, write-allocate policy.
- 32-bit word accesses with byte enables.
- True-LRU replacement.
- Valid/ready request handshakes on both sides.
- Dirty-victim writeback before refill, so main memory only sees whole-block transfers.

---
 rtl/l1_dcache_wb.sv | 219 +++++++++++++++++++++
 tb/tb_l1_dcache_wb.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache_wb.sv
// l1_dcache_wb: N-way set-associative write-back, write-allocate L1 D-cache, true-LRU.
// Ports: clk_i/rst_n; cpu_req_*/cpu_rsp_* CPU side; mem_req_*/mem_rsp_* block side.
// Optional: define L1_DCACHE_STATS_EN to add hit_cnt_o, miss_cnt_o, wb_cnt_o.
module l1_dcache_wb #(
  parameter int WAYS        = 4,
  parameter int SETS        = 64,
  parameter int BLOCK_BYTES = 16,
  parameter int ADDR_W      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     cpu_req_valid_i,
  output logic                     cpu_req_ready_o,
  input  logic                     cpu_req_we_i,
  input  logic [3:0]               cpu_req_be_i,
  input  logic [ADDR_W-1:0]        cpu_req_addr_i,
  input  logic [31:0]              cpu_req_wdata_i,
  output logic                     cpu_rsp_valid_o,
  output logic [31:0]              cpu_rsp_rdata_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic                     mem_req_we_o,
  output logic [ADDR_W-1:0]        mem_req_addr_o,
  output logic [8*BLOCK_BYTES-1:0] mem_req_wdata_o,
  input  logic                     mem_rsp_valid_i,
  input  logic [8*BLOCK_BYTES-1:0] mem_rsp_rdata_i
`ifdef L1_DCACHE_STATS_EN
  ,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o,
  output logic [31:0]              wb_cnt_o
`endif
);
  localparam int OFF_W   = $clog2(BLOCK_BYTES);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int BLOCK_W = 8 * BLOCK_BYTES;
  localparam int WAY_W   = $clog2(WAYS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_RESP
  } state_t;

  state_t r_state, w_next;

  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [WAY_W-1:0]  r_way;
  logic              r_rf_acked;

  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAYS-1:0]    r_dirty [SETS];
  logic [WAY_W-1:0]   r_age   [SETS][WAYS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [BLOCK_W-1:0] r_data  [SETS][WAYS];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [OFF_W+2:0]   w_bit;
  logic [BLOCK_W-1:0] w_line;
  logic               w_hit, w_inv, w_vic_dirty;
  logic [WAY_W-1:0]   w_hit_way, w_vic;
  logic               w_fill, w_wb_hs;
  logic               w_unused;

  assign w_unused = ^cpu_req_addr_i[1:0];
  assign w_idx    = r_addr[OFF_W +: IDX_W];
  assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
  assign w_bit    = {r_addr[OFF_W-1:0], 3'b000};
  assign w_line   = r_data[w_idx][r_way];

  // Lowest invalid way wins; otherwise the way whose age is oldest.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_vic     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_inv = 1'b1;
        w_vic = WAY_W'(w);
      end
    end
    if (!w_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_vic = WAY_W'(w);
      end
    end
  end

  assign w_vic_dirty = r_valid[w_idx][w_vic] & r_dirty[w_idx][w_vic];
  assign w_wb_hs     = (r_state == S_WB) && mem_req_ready_i;
  // Refill data may arrive in the same cycle as the request handshake.
  assign w_fill      = (r_state == S_REFILL) && mem_rsp_valid_i &&
                       (r_rf_acked || mem_req_ready_i);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (cpu_req_valid_i) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit)            w_next = S_RESP;
        else if (w_vic_dirty) w_next = S_WB;
        else                  w_next = S_REFILL;
      end
      S_WB:     if (mem_req_ready_i) w_next = S_REFILL;
      S_REFILL: if (w_fill) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_req_ready_o = (r_state == S_IDLE);
    cpu_rsp_valid_o = (r_state == S_RESP);
    mem_req_valid_o = (r_state == S_WB) ||
                      (r_state == S_REFILL && !r_rf_acked);
    mem_req_we_o    = (r_state == S_WB);
    mem_req_addr_o  = '0;
    mem_req_wdata_o = '0;
    cpu_rsp_rdata_o = '0;
    if (r_state == S_WB) begin
      mem_req_addr_o  = {r_tag[w_idx][r_way], w_idx, {OFF_W{1'b0}}};
      mem_req_wdata_o = w_line;
    end
    if (r_state == S_REFILL && !r_rf_acked)
      mem_req_addr_o = {w_tag, w_idx, {OFF_W{1'b0}}};
    if (r_state == S_RESP && !r_we)
      cpu_rsp_rdata_o = w_line[w_bit +: 32];
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_way      <= '0;
      r_rf_acked <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
      end
    end else begin
      if (cpu_req_valid_i && cpu_req_ready_o) begin
        r_we    <= cpu_req_we_i;
        r_be    <= cpu_req_be_i;
        r_addr  <= {cpu_req_addr_i[ADDR_W-1:2], 2'b00};
        r_wdata <= cpu_req_wdata_i;
      end
      if (r_state == S_LOOKUP) r_way <= w_hit ? w_hit_way : w_vic;
      r_rf_acked <= (r_state == S_REFILL) &&
                    (r_rf_acked || mem_req_ready_i);
      if (w_wb_hs) r_dirty[w_idx][r_way] <= 1'b0;
      if (w_fill) begin
        r_valid[w_idx][r_way] <= 1'b1;
        r_dirty[w_idx][r_way] <= 1'b0;
      end
      if (r_state == S_RESP) begin
        if (r_we && |r_be) r_dirty[w_idx][r_way] <= 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (r_age[w_idx][w] < r_age[w_idx][r_way])
            r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
        end
        r_age[w_idx][r_way] <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_tag[w_idx][r_way]  <= w_tag;
      r_data[w_idx][r_way] <= mem_rsp_rdata_i;
    end
    if (r_state == S_RESP && r_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b])
          r_data[w_idx][r_way][w_bit + 8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

`ifdef L1_DCACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (r_state == S_LOOKUP) begin
        if (w_hit && r_hit_cnt != '1)   r_hit_cnt  <= r_hit_cnt + 1'b1;
        if (!w_hit && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (w_wb_hs && r_wb_cnt != '1) r_wb_cnt <= r_wb_cnt + 1'b1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
  assign wb_cnt_o   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_l1_dcache_wb.sv
// tb_l1_dcache_wb: directed + random checks of l1_dcache_wb against a
// recency-list cache model and a block memory responder.
module tb_l1_dcache_wb;
  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         cpu_req_valid_i;
  logic         cpu_req_ready_o;
  logic         cpu_req_we_i;
  logic [3:0]   cpu_req_be_i;
  logic [31:0]  cpu_req_addr_i;
  logic [31:0]  cpu_req_wdata_i;
  logic         cpu_rsp_valid_o;
  logic [31:0]  cpu_rsp_rdata_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic         mem_req_we_o;
  logic [31:0]  mem_req_addr_o;
  logic [127:0] mem_req_wdata_o;
  logic         mem_rsp_valid_i;
  logic [127:0] mem_rsp_rdata_i;
`ifdef L1_DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

  l1_dcache_wb dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .cpu_req_valid_i (cpu_req_valid_i),
    .cpu_req_ready_o (cpu_req_ready_o),
    .cpu_req_we_i    (cpu_req_we_i),
    .cpu_req_be_i    (cpu_req_be_i),
    .cpu_req_addr_i  (cpu_req_addr_i),
    .cpu_req_wdata_i (cpu_req_wdata_i),
    .cpu_rsp_valid_o (cpu_rsp_valid_o),
    .cpu_rsp_rdata_o (cpu_rsp_rdata_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_rdata_i (mem_rsp_rdata_i)
`ifdef L1_DCACHE_STATS_EN
    ,
    .hit_cnt_o       (hit_cnt_o),
    .miss_cnt_o      (miss_cnt_o),
    .wb_cnt_o        (wb_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  int n_rsp = 0;
  int g_hold = -1;

  logic [127:0] phys_mem [logic [31:0]];
  logic [127:0] ref_mem  [logic [31:0]];
  logic         lg_we   [$];
  logic [31:0]  lg_addr [$];
  logic [127:0] lg_data [$];

  bit           m_valid [64][4];
  bit           m_dirty [64][4];
  logic [21:0]  m_tag   [64][4];
  logic [127:0] m_data  [64][4];
  int           m_ord   [64][4];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = (a + 32'(4*k)) ^ 32'h9E37_79B9;
    return l;
  endfunction

  function automatic logic [127:0] phys_line(input logic [31:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_ord[s][w]   = w;
      end
  endfunction

  // m_ord[s] lists ways most-recent first; the last entry is the LRU way.
  task automatic m_access(input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output bit hit, output bit wb,
                          output logic [31:0] wb_addr,
                          output logic [127:0] wb_data,
                          output logic [31:0] rd);
    logic [5:0]  si;
    logic [21:0] t;
    int s, way, wi, p;
    si = addr[9:4];
    s  = int'(si);
    t  = addr[31:10];
    wi = int'(addr[3:2]);
    way = -1;
    wb = 0;
    wb_addr = '0;
    wb_data = '0;
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    hit = (way >= 0);
    if (!hit) begin
      for (int w = 0; w < 4; w++)
        if (!m_valid[s][w] && way < 0) way = w;
      if (way < 0) way = m_ord[s][3];
      if (m_valid[s][way] && m_dirty[s][way]) begin
        wb = 1;
        wb_addr = {m_tag[s][way], si, 4'h0};
        wb_data = m_data[s][way];
        ref_mem[wb_addr] = wb_data;
      end
      m_valid[s][way] = 1;
      m_dirty[s][way] = 0;
      m_tag[s][way]   = t;
      m_data[s][way]  = ref_line({t, si, 4'h0});
    end
    rd = we ? 32'h0 : m_data[s][way][wi*32 +: 32];
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_data[s][way][wi*32 + 8*b +: 8] = wd[8*b +: 8];
      if (be != 4'h0) m_dirty[s][way] = 1;
    end
    p = 0;
    for (int k = 0; k < 4; k++) if (m_ord[s][k] == way) p = k;
    for (int k = p; k > 0; k--) m_ord[s][k] = m_ord[s][k-1];
    m_ord[s][0] = way;
  endtask

  task automatic cpu_access(input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat);
    bit hit, wb;
    logic [31:0]  wa, er;
    logic [127:0] wdt;
    int en;
    m_access(we, be, addr, wd, hit, wb, wa, wdt, er);
    lg_we.delete();
    lg_addr.delete();
    lg_data.delete();
    @(negedge clk_i);
    chk("ready_idle", cpu_req_ready_o, 1);
    cpu_req_valid_i = 1;
    cpu_req_we_i    = we;
    cpu_req_be_i    = be;
    cpu_req_addr_i  = addr;
    cpu_req_wdata_i = wd;
    @(posedge clk_i);
    @(negedge clk_i);
    cpu_req_valid_i = 0;
    lat = 1;
    while (!cpu_rsp_valid_o && lat < 300) begin
      @(negedge clk_i);
      lat++;
    end
    rd = cpu_rsp_rdata_o;
    if (!cpu_rsp_valid_o) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    chk("rdata", rd, er);
    if (hit) chk("hit_lat", lat, 2);
    en = hit ? 0 : (wb ? 2 : 1);
    chk("mem_n", lg_addr.size(), en);
    if (lg_addr.size() == en && !hit) begin
      if (wb) begin
        chk("wb_we", lg_we[0], 1);
        chk("wb_addr", lg_addr[0], wa);
        chk("wb_data", lg_data[0], wdt);
      end
      chk("rf_we", lg_we[en-1], 0);
      chk("rf_addr", lg_addr[en-1], {addr[31:4], 4'h0});
    end
    @(negedge clk_i);
    chk("rsp_pulse", cpu_rsp_valid_o, 0);
    chk("ready_after", cpu_req_ready_o, 1);
  endtask

  task automatic do_reset();
    cpu_req_valid_i = 0;
    rst_n = 0;
    repeat (2) @(negedge clk_i);
    rst_n = 1;
    m_reset();
    @(negedge clk_i);
  endtask

  always @(posedge clk_i) if (cpu_rsp_valid_o) n_rsp++;

  logic         h_we;
  logic [31:0]  h_addr;
  logic [127:0] h_data;
  int           h_d, h_rl, h_i;
  bit           h_abort;

  initial begin
    mem_req_ready_i = 0;
    mem_rsp_valid_i = 0;
    mem_rsp_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_n && mem_req_valid_o) begin
        h_we   = mem_req_we_o;
        h_addr = mem_req_addr_o;
        h_data = mem_req_wdata_o;
        h_d    = (g_hold >= 0) ? g_hold : int'($urandom_range(0, 3));
        h_rl   = (g_hold >= 0) ? 0 : int'($urandom_range(0, 2));
        h_abort = 0;
        h_i = 0;
        while (h_i < h_d && !h_abort) begin
          @(negedge clk_i);
          if (!mem_req_valid_o) h_abort = 1;
          else begin
            chk("hold_we", mem_req_we_o, h_we);
            chk("hold_addr", mem_req_addr_o, h_addr);
            chk("hold_wdata", mem_req_wdata_o, h_data);
          end
          h_i++;
        end
        if (!h_abort) begin
          mem_req_ready_i = 1;
          lg_we.push_back(h_we);
          lg_addr.push_back(h_addr);
          lg_data.push_back(h_data);
          if (h_we) phys_mem[h_addr] = h_data;
          else if (h_rl == 0) begin
            mem_rsp_valid_i = 1;
            mem_rsp_rdata_i = phys_line(h_addr);
          end
          @(negedge clk_i);
          mem_req_ready_i = 0;
          mem_rsp_valid_i = 0;
          if (!h_we && h_rl > 0) begin
            repeat (h_rl - 1) @(negedge clk_i);
            mem_rsp_valid_i = 1;
            mem_rsp_rdata_i = phys_line(h_addr);
            @(negedge clk_i);
            mem_rsp_valid_i = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [127:0] l;
    logic [31:0]  rd, a;
    int lat, n0;
    bit seen;
    rst_n = 0;
    cpu_req_valid_i = 0;
    cpu_req_we_i    = 0;
    cpu_req_be_i    = 0;
    cpu_req_addr_i  = 0;
    cpu_req_wdata_i = 0;
    l = init_line(32'h1000);
    l[63:32] = 32'hDEAD_BEEF;
    phys_mem[32'h1000] = l;
    ref_mem[32'h1000]  = l;
    m_reset();
    repeat (3) @(negedge clk_i);
    chk("rst_ready", cpu_req_ready_o, 1);
    chk("rst_rsp_valid", cpu_rsp_valid_o, 0);
    chk("rst_rsp_rdata", cpu_rsp_rdata_o, 0);
    chk("rst_mem_valid", mem_req_valid_o, 0);
    chk("rst_mem_we", mem_req_we_o, 0);
    chk("rst_mem_addr", mem_req_addr_o, 0);
    chk("rst_mem_wdata", mem_req_wdata_o, 0);
    rst_n = 1;
    @(negedge clk_i);

    cpu_access(0, 4'h0, 32'h1004, 0, rd, lat);
    chk("cold_rdata", rd, 32'hDEAD_BEEF);
    if (lg_addr.size() > 0) chk("cold_refill_addr", lg_addr[0], 32'h1000);
    cpu_access(0, 4'h0, 32'h1004, 0, rd, lat);
    chk("rehit_lat", lat, 2);
    chk("rehit_nomem", lg_addr.size(), 0);
    cpu_access(1, 4'h3, 32'h1004, 32'h1234_5678, rd, lat);
    cpu_access(0, 4'h0, 32'h1004, 0, rd, lat);
    chk("merge_rdata", rd, 32'hDEAD_5678);

    g_hold = 7;
    cpu_access(0, 4'h0, 32'h2008, 0, rd, lat);
    g_hold = -1;
    chk("hold7_lat", lat, 10);

    do_reset();
    cpu_access(0, 4'h0, 32'h0000, 0, rd, lat);
    cpu_access(1, 4'hF, 32'h0400, 32'hCAFE_F00D, rd, lat);
    cpu_access(0, 4'h0, 32'h0800, 0, rd, lat);
    cpu_access(0, 4'h0, 32'h0C00, 0, rd, lat);
    cpu_access(0, 4'h0, 32'h0000, 0, rd, lat);
    cpu_access(0, 4'h0, 32'h1000, 0, rd, lat);
    chk("evict_n", lg_addr.size(), 2);
    if (lg_addr.size() == 2) begin
      chk("evict_wb_we", lg_we[0], 1);
      chk("evict_wb_addr", lg_addr[0], 32'h0400);
      chk("evict_wb_word0", lg_data[0][31:0], 32'hCAFE_F00D);
      chk("evict_rf_addr", lg_addr[1], 32'h1000);
    end

    cpu_access(1, 4'hF, 32'h0010, 32'h1111_2222, rd, lat);
    cpu_access(0, 4'h0, 32'h0410, 0, rd, lat);
    cpu_access(0, 4'h0, 32'h0810, 0, rd, lat);
    cpu_access(0, 4'h0, 32'h0C10, 0, rd, lat);
    g_hold = 20;
    @(negedge clk_i);
    cpu_req_valid_i = 1;
    cpu_req_we_i    = 0;
    cpu_req_be_i    = 0;
    cpu_req_addr_i  = 32'h1010;
    @(posedge clk_i);
    @(negedge clk_i);
    cpu_req_valid_i = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (mem_req_valid_o && mem_req_we_o) seen = 1;
    end
    chk("rst_wb_seen", seen, 1);
    chk("rst_wb_addr", mem_req_addr_o, 32'h0010);
    n0 = n_rsp;
    #2 rst_n = 0;
    #1;
    chk("rst_async_mvalid", mem_req_valid_o, 0);
    repeat (2) @(negedge clk_i);
    rst_n = 1;
    g_hold = -1;
    m_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_rel_ready", cpu_req_ready_o, 1);
    chk("rst_no_rsp", n_rsp, n0);
    cpu_access(0, 4'h0, 32'h1010, 0, rd, lat);
    chk("rst_prev_miss", lg_addr.size(), 1);

    for (int n = 0; n < 400; n++) begin
      logic       we;
      logic [3:0] be;
      we = 1'($urandom_range(0, 1));
      be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      a  = (32'($urandom_range(0, 5)) << 10) |
           (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      cpu_access(we, be, a, $urandom, rd, lat);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
